axil_sum_bank: RTL and testbench

AXIL_SUM_BANK -- requirements
Module: axil_sum_bank

---
 rtl/axil_sum_bank.sv | 195 +++++++++++++++++++
 tb/tb_axil_sum_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_sum_bank.sv
// axil_sum_bank: AXI4-Lite slave with NADD addend registers, a read-only
// SUM of all addends and a read-only WCOUNT of successful writes.
// Ports: clk, resetn (sync, active-low), S_AXI_AW*/W*/B* write channels,
//        S_AXI_AR*/R* read channels. AWPROT/ARPROT are ignored.
module axil_sum_bank #(
    parameter int AW   = 8,
    parameter int NADD = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] S_AXI_AWADDR,
    input  logic          S_AXI_AWVALID,
    output logic          S_AXI_AWREADY,
    input  logic [2:0]    S_AXI_AWPROT,
    input  logic [31:0]   S_AXI_WDATA,
    input  logic [3:0]    S_AXI_WSTRB,
    input  logic          S_AXI_WVALID,
    output logic          S_AXI_WREADY,
    output logic [1:0]    S_AXI_BRESP,
    output logic          S_AXI_BVALID,
    input  logic          S_AXI_BREADY,
    input  logic [AW-1:0] S_AXI_ARADDR,
    input  logic          S_AXI_ARVALID,
    output logic          S_AXI_ARREADY,
    input  logic [2:0]    S_AXI_ARPROT,
    output logic [31:0]   S_AXI_RDATA,
    output logic [1:0]    S_AXI_RRESP,
    output logic          S_AXI_RVALID,
    input  logic          S_AXI_RREADY
);

    localparam int IW = AW - 2;
    localparam logic [IW-1:0] I_SUM = IW'(NADD);
    localparam logic [IW-1:0] I_CNT = IW'(NADD + 1);
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [31:0]   addend [NADD];
    logic [31:0]   wcount;
    logic [31:0]   sum;
    logic          aw_held, w_held;
    logic [IW-1:0] aw_idx;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic          commit;
    logic [1:0]    w_resp;
    logic          ar_hs;
    logic [IW-1:0] ar_idx;
    logic [31:0]   r_data_c;
    logic [1:0]    r_resp_c;
    logic          unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign ar_idx = S_AXI_ARADDR[AW-1:2];
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NADD; i++)
            sum = sum + addend[i];
    end

    always_comb begin
        if (aw_idx < I_SUM)
            w_resp = OKAY;
        else if (aw_idx == I_SUM || aw_idx == I_CNT)
            w_resp = SLVERR;
        else
            w_resp = DECERR;
    end

    always_comb begin
        r_data_c = '0;
        r_resp_c = DECERR;
        for (int i = 0; i < NADD; i++) begin
            if (ar_idx == IW'(i)) begin
                r_data_c = addend[i];
                r_resp_c = OKAY;
            end
        end
        if (ar_idx == I_SUM) begin
            r_data_c = sum;
            r_resp_c = OKAY;
        end
        if (ar_idx == I_CNT) begin
            r_data_c = wcount;
            r_resp_c = OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Readies are gated by resetn so they stay low throughout reset.
    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        commit        = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = resetn && !aw_held;
                S_AXI_WREADY  = resetn && !w_held;
                if (aw_held && w_held) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY)
                    w_next = W_IDLE;
            end
        endcase
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = resetn;
                if (S_AXI_ARVALID && resetn)
                    r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY)
                    r_next = R_IDLE;
            end
        endcase
    end

    // A read captured on a commit edge sees the pre-write register values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NADD; i++)
                addend[i] <= '0;
            wcount      <= '0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            S_AXI_BRESP <= OKAY;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= OKAY;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_idx  <= S_AXI_AWADDR[AW-1:2];
                aw_held <= 1'b1;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
                w_held <= 1'b1;
            end
            if (commit) begin
                aw_held     <= 1'b0;
                w_held      <= 1'b0;
                S_AXI_BRESP <= w_resp;
                if (w_resp == OKAY) begin
                    wcount <= wcount + 32'd1;
                    for (int i = 0; i < NADD; i++)
                        for (int b = 0; b < 4; b++)
                            if (aw_idx == IW'(i) && w_strb[b])
                                addend[i][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
            if (ar_hs) begin
                S_AXI_RDATA <= r_data_c;
                S_AXI_RRESP <= r_resp_c;
            end
        end
    end

endmodule

// File: tb/tb_axil_sum_bank.sv
// tb_axil_sum_bank: directed self-checking bench for axil_sum_bank
// (AW=8, NADD=4): map, strobes, ordering, backpressure, errors, reset.
module tb_axil_sum_bank;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_sum_bank #(.AW(8), .NADD(4)) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_AWPROT(3'd0),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_ARPROT(3'd0),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold,
                      output logic [1:0] resp);
        bit ad = 0, wd = 0, ah, wh, stable = 1;
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1;
        while (!(ad && wd) && n < 50) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(negedge clk); n++;
            if (ah) begin awvalid = 0; ad = 1; end
            if (wh) begin wvalid = 0; wd = 1; end
        end
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_timeout", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        repeat (hold) begin
            @(negedge clk);
            if (!bvalid || bresp !== resp) stable = 0;
        end
        if (hold > 0) check("b_stable", {31'd0, stable}, 32'd1);
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("b_once", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d,
                      output logic [1:0] resp);
        bit h;
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1;
        while (arvalid && n < 50) begin
            h = arready;
            @(negedge clk); n++;
            if (h) arvalid = 0;
        end
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("r_timeout", {31'd0, rvalid}, 32'd1);
        d = rdata; resp = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    int          n;

    initial begin
        resetn = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0;
        wvalid = 0; bready = 0; araddr = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        resetn = 1;
        @(negedge clk);
        check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

        wr(8'h00, 32'h10, 4'hF, 0, r); check("w_a0", {30'd0, r}, 32'd0);
        wr(8'h0C, 32'h20, 4'hF, 0, r); check("w_a3", {30'd0, r}, 32'd0);
        rd(8'h10, d, r); check("sum1", d, 32'h30);
        check("sum1_resp", {30'd0, r}, 32'd0);
        rd(8'h14, d, r); check("wcount2", d, 32'd2);

        wr(8'h04, 32'h11223344, 4'hF, 0, r);
        wr(8'h04, 32'hAABBCCDD, 4'b0101, 0, r);
        rd(8'h04, d, r); check("strb_a1", d, 32'h11BB33DD);
        wr(8'h08, 32'hDEADBEEF, 4'h0, 0, r);
        check("strb0_resp", {30'd0, r}, 32'd0);
        rd(8'h08, d, r); check("strb0_a2", d, 32'h0);
        rd(8'h14, d, r); check("wcount5", d, 32'd5);

        wr(8'h10, 32'h1, 4'hF, 0, r); check("w_sum_err", {30'd0, r}, 32'd2);
        wr(8'h14, 32'h1, 4'hF, 0, r); check("w_cnt_err", {30'd0, r}, 32'd2);
        wr(8'h1C, 32'h1, 4'hF, 0, r); check("w_dec", {30'd0, r}, 32'd3);
        rd(8'h1C, d, r); check("r_dec_data", d, 32'h0);
        check("r_dec_resp", {30'd0, r}, 32'd3);
        rd(8'h14, d, r); check("wcount_err", d, 32'd5);
        rd(8'h10, d, r); check("sum_err", d, 32'h11BB340D);
        rd(8'h0D, d, r); check("lowbits_ign", d, 32'h20);

        // W three cycles ahead of AW.
        @(negedge clk);
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
        check("wf_wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 0;
        check("wf_wready_low", {31'd0, wready}, 32'd0);
        ok = 1;
        repeat (3) begin
            if (bvalid || !awready) ok = 0;
            @(negedge clk);
        end
        check("wf_wait", {31'd0, ok}, 32'd1);
        awaddr = 8'h08; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("wf_pending", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        check("wf_bvalid", {31'd0, bvalid}, 32'd1);
        check("wf_bresp", {30'd0, bresp}, 32'd0);
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("wf_b_once", {31'd0, bvalid}, 32'd0);
        check("wf_ready_back", {30'd0, awready, wready}, 32'd3);

        wr(8'h0C, 32'h7, 4'hF, 5, r); check("hold_resp", {30'd0, r}, 32'd0);
        rd(8'h10, d, r); check("sum_mid", d, 32'h11BB33F9);
        rd(8'h14, d, r); check("wcount7", d, 32'd7);

        wr(8'h00, 32'hFFFFFFFF, 4'hF, 0, r);
        wr(8'h04, 32'hFFFFFFFF, 4'hF, 0, r);
        wr(8'h08, 32'h0, 4'hF, 0, r);
        wr(8'h0C, 32'h0, 4'hF, 0, r);
        rd(8'h10, d, r); check("sum_wrap", d, 32'hFFFFFFFE);

        // AR handshake on the same edge as the commit to ADDEND2.
        @(negedge clk);
        awaddr = 8'h08; wdata = 32'h99; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        araddr = 8'h08; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        check("rc_rvalid", {31'd0, rvalid}, 32'd1);
        check("rc_old", rdata, 32'h0);
        check("rc_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        rd(8'h08, d, r); check("rc_new", d, 32'h99);

        // R held off while a write completes.
        @(negedge clk);
        araddr = 8'h00; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        wr(8'h0C, 32'h44, 4'hF, 0, r); check("rbp_wresp", {30'd0, r}, 32'd0);
        check("rbp_rvalid", {31'd0, rvalid}, 32'd1);
        check("rbp_rdata", rdata, 32'hFFFFFFFF);
        rready = 1;
        @(negedge clk);
        rready = 0;
        rd(8'h14, d, r); check("wcount13", d, 32'd13);

        // Reset with BVALID pending.
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h123; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("rst_mid_bv", {31'd0, bvalid}, 32'd1);
        resetn = 0;
        @(negedge clk);
        check("rst_mid_bv0", {31'd0, bvalid}, 32'd0);
        check("rst_mid_rdy", {29'd0, awready, wready, arready}, 32'd0);
        resetn = 1;
        rd(8'h00, d, r); check("rst_a0", d, 32'h0);
        rd(8'h04, d, r); check("rst_a1", d, 32'h0);
        rd(8'h10, d, r); check("rst_sum", d, 32'h0);
        rd(8'h14, d, r); check("rst_wcount", d, 32'h0);

        // Data latched then reset: the held W must be discarded.
        @(negedge clk);
        wdata = 32'hBAD; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0; resetn = 0;
        @(negedge clk);
        resetn = 1;
        awaddr = 8'h00; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        ok = 1;
        repeat (4) begin
            if (bvalid) ok = 0;
            @(negedge clk);
        end
        check("partial_drop", {31'd0, ok}, 32'd1);
        wdata = 32'h77; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("partial_bv", {31'd0, bvalid}, 32'd1);
        bready = 1;
        @(negedge clk);
        bready = 0;
        rd(8'h00, d, r); check("partial_a0", d, 32'h77);
        rd(8'h14, d, r); check("partial_wcount", d, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
